// File: rtl/delaychain_pkg.sv
// Shared types and default widths for the delay-chain measurement sequencer.
package delaychain_pkg;

    // Default widths and timing shared by the sequencer, the chain top and the bench
    localparam int DC_CNT_W      = 16;
    localparam int DC_RUN_W      = 8;
    localparam int DC_ACC_W      = 24;
    localparam int DC_SETTLE_CYC = 64;
    localparam int DC_SYNC_N     = 2;

    // Sequencer states, in the order a normal measurement walks through them
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        LAUNCH = 3'd2,
        WAIT   = 3'd3,
        RECORD = 3'd4,
        DONE   = 3'd5
    } seq_state_t;

    // True for the states in which the chain must be held in test mode
    function automatic logic chain_active(input seq_state_t s);
        return (s == SETTLE) || (s == LAUNCH) || (s == WAIT) || (s == RECORD);
    endfunction

endpackage

// File: rtl/dc_sync.sv
// Multi-flop synchronizer for the asynchronous chain output.
module dc_sync
#(
    parameter int SYNC_N = 2
)
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_N-1:0] stage_q;
    logic [SYNC_N-1:0] stage_d;

    // Each stage takes the previous one; stage 0 takes the raw input
    generate
        for (genvar gi = 0; gi < SYNC_N; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign stage_d[gi] = d;
            end else begin : g_rest
                assign stage_d[gi] = stage_q[gi-1];
            end
        end
    endgenerate

    // Shift chain, cleared to 0 on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[SYNC_N-1];

endmodule

// File: rtl/delaychain_seq.sv
// Measurement sequencer for one delay chain: settles the chain, launches alternating
// edges on chain_din, counts clk cycles until each edge reaches chain_dout, and
// accumulates sum/min/max latency over a programmable number of runs.
module delaychain_seq
    import delaychain_pkg::*;
#(
    parameter int CNT_W      = DC_CNT_W,
    parameter int RUN_W      = DC_RUN_W,
    parameter int ACC_W      = DC_ACC_W,
    parameter int SETTLE_CYC = DC_SETTLE_CYC,
    parameter int SYNC_N     = DC_SYNC_N
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [RUN_W-1:0] num_runs,
    input  logic [CNT_W-1:0] timeout,
    input  logic             chain_dout,
    output logic             chain_din,
    output logic             chain_test,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [ACC_W-1:0] lat_sum,
    output logic [CNT_W-1:0] lat_min,
    output logic [CNT_W-1:0] lat_max
);

    // Settle counter must be able to hold SETTLE_CYC-1
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;

    // Synchronized chain output; its SYNC_N stages are part of the reported latency
    logic dout_sync;

    dc_sync #(
        .SYNC_N (SYNC_N)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (chain_dout),
        .q   (dout_sync)
    );

    seq_state_t       state_q,       state_d;
    logic             pol_q,         pol_d;
    logic [RUN_W-1:0] run_cnt_q,     run_cnt_d;
    logic [RUN_W-1:0] runs_q,        runs_d;
    logic [CNT_W-1:0] tmo_q,         tmo_d;
    logic [SET_W-1:0] settle_cnt_q,  settle_cnt_d;
    logic [CNT_W-1:0] lat_cnt_q,     lat_cnt_d;
    logic             chain_din_q,   chain_din_d;
    logic             chain_test_q,  chain_test_d;
    logic             busy_q,        busy_d;
    logic             done_q,        done_d;
    logic             timeout_err_q, timeout_err_d;
    logic [ACC_W-1:0] lat_sum_q,     lat_sum_d;
    logic [CNT_W-1:0] lat_min_q,     lat_min_d;
    logic [CNT_W-1:0] lat_max_q,     lat_max_d;

    // One extra bit on the accumulator add exposes the carry used for saturation
    logic [ACC_W:0]   sum_ext;
    logic [RUN_W-1:0] run_next;

    // Next-state, counter and result logic; outputs are derived from the next state so
    // they are registered alongside it
    always_comb begin
        state_d       = state_q;
        pol_d         = pol_q;
        run_cnt_d     = run_cnt_q;
        runs_d        = runs_q;
        tmo_d         = tmo_q;
        settle_cnt_d  = settle_cnt_q;
        lat_cnt_d     = lat_cnt_q;
        timeout_err_d = timeout_err_q;
        lat_sum_d     = lat_sum_q;
        lat_min_d     = lat_min_q;
        lat_max_d     = lat_max_q;
        sum_ext       = {1'b0, lat_sum_q} + {{(ACC_W + 1 - CNT_W){1'b0}}, lat_cnt_q};
        run_next      = run_cnt_q + RUN_W'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Fresh sequence: results back to their reset values, first edge 0->1
                    timeout_err_d = 1'b0;
                    lat_sum_d     = '0;
                    lat_min_d     = '1;
                    lat_max_d     = '0;
                    runs_d        = num_runs;
                    tmo_d         = timeout;
                    pol_d         = 1'b0;
                    run_cnt_d     = '0;
                    settle_cnt_d  = '0;
                    lat_cnt_d     = '0;
                    state_d       = (num_runs == '0) ? DONE : SETTLE;
                end
            end

            SETTLE: begin
                // Need SETTLE_CYC consecutive cycles with the chain output at the
                // current level; any disagreement restarts the count
                if (dout_sync != pol_q) begin
                    settle_cnt_d = '0;
                end else if (settle_cnt_q == SET_W'(SETTLE_CYC - 1)) begin
                    state_d = LAUNCH;
                end else begin
                    settle_cnt_d = settle_cnt_q + SET_W'(1);
                end
            end

            LAUNCH: begin
                pol_d     = ~pol_q;
                lat_cnt_d = '0;
                state_d   = WAIT;
            end

            WAIT: begin
                // Arrival takes priority over timeout on the same cycle
                if (dout_sync == chain_din_q) begin
                    state_d = RECORD;
                end else if (lat_cnt_q == tmo_q) begin
                    timeout_err_d = 1'b1;
                    state_d       = DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q + CNT_W'(1);
                end
            end

            RECORD: begin
                lat_sum_d = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
                if (lat_cnt_q < lat_min_q) begin
                    lat_min_d = lat_cnt_q;
                end
                if (lat_cnt_q > lat_max_q) begin
                    lat_max_d = lat_cnt_q;
                end
                run_cnt_d    = run_next;
                settle_cnt_d = '0;
                state_d      = (run_next == runs_q) ? DONE : SETTLE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides any transition; partially accumulated results are kept
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end

        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
        chain_test_d = chain_active(state_d);
        chain_din_d  = chain_test_d & pol_d;
    end

    // Sequencer state, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pol_q         <= 1'b0;
            run_cnt_q     <= '0;
            runs_q        <= '0;
            tmo_q         <= '0;
            settle_cnt_q  <= '0;
            lat_cnt_q     <= '0;
            chain_din_q   <= 1'b0;
            chain_test_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            lat_sum_q     <= '0;
            lat_min_q     <= '1;
            lat_max_q     <= '0;
        end else begin
            state_q       <= state_d;
            pol_q         <= pol_d;
            run_cnt_q     <= run_cnt_d;
            runs_q        <= runs_d;
            tmo_q         <= tmo_d;
            settle_cnt_q  <= settle_cnt_d;
            lat_cnt_q     <= lat_cnt_d;
            chain_din_q   <= chain_din_d;
            chain_test_q  <= chain_test_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
            lat_sum_q     <= lat_sum_d;
            lat_min_q     <= lat_min_d;
            lat_max_q     <= lat_max_d;
        end
    end

    assign chain_din   = chain_din_q;
    assign chain_test  = chain_test_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;
    assign lat_sum     = lat_sum_q;
    assign lat_min     = lat_min_q;
    assign lat_max     = lat_max_q;

endmodule

// File: tb/tb_delaychain_seq.sv
// Bench for delaychain_seq: the chain is a clocked shift register with separate
// rise/fall taps; expected results are queued at start and compared at done.
module tb_delaychain_seq;
    import delaychain_pkg::*;

    localparam int CNT_W  = DC_CNT_W;
    localparam int RUN_W  = DC_RUN_W;
    localparam int ACC_W  = DC_ACC_W;
    localparam int SYNC_N = DC_SYNC_N;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [RUN_W-1:0] num_runs = '0;
    logic [CNT_W-1:0] timeout = '0;
    logic             chain_dout;
    logic             chain_din;
    logic             chain_test;
    logic             busy;
    logic             done;
    logic             timeout_err;
    logic [ACC_W-1:0] lat_sum;
    logic [CNT_W-1:0] lat_min;
    logic [CNT_W-1:0] lat_max;

    always #5 clk = ~clk;

    delaychain_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .num_runs    (num_runs),
        .timeout     (timeout),
        .chain_dout  (chain_dout),
        .chain_din   (chain_din),
        .chain_test  (chain_test),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .lat_sum     (lat_sum),
        .lat_min     (lat_min),
        .lat_max     (lat_max)
    );

    // Chain model: rising edges appear after tap_r+1 cycles, falling after tap_f+1
    logic [255:0] sr = '0;
    logic [7:0]   tap_r = 8'd4;
    logic [7:0]   tap_f = 8'd4;
    always @(posedge clk) sr <= {sr[254:0], chain_din};
    assign chain_dout = sr[tap_r] | sr[tap_f];

    // Event counters sampled at the clock edge
    int   n_done = 0;
    int   n_launch = 0;
    int   n_test_cyc = 0;
    logic din_prev = 1'b0;
    always @(posedge clk) begin
        if (done) n_done <= n_done + 1;
        if (chain_test && (chain_din != din_prev)) n_launch <= n_launch + 1;
        if (chain_test) n_test_cyc <= n_test_cyc + 1;
        din_prev <= chain_din;
    end

    typedef struct {
        string            tag;
        logic             err;
        logic [ACC_W-1:0] sum;
        logic [CNT_W-1:0] mn;
        logic [CNT_W-1:0] mx;
        int               launches;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: run r uses the rise delay when r is even, fall delay when odd
    function automatic exp_t model(input string tag, input int nr, input int tmo,
                                   input int dr, input int df);
        exp_t e;
        int   sum = 0;
        int   lat;
        e.tag = tag;
        e.err = 1'b0;
        e.mn = '1;
        e.mx = '0;
        e.launches = 0;
        for (int r = 0; r < nr; r++) begin
            lat = (((r % 2) == 0) ? dr : df) + SYNC_N;
            e.launches++;
            if (lat > tmo) begin
                e.err = 1'b1;
                break;
            end
            sum += lat;
            if (lat < int'(e.mn)) e.mn = CNT_W'(lat);
            if (lat > int'(e.mx)) e.mx = CNT_W'(lat);
        end
        e.sum = ACC_W'(sum);
        return e;
    endfunction

    task automatic compare_results();
        exp_t e;
        e = sb_q.pop_front();
        chk({e.tag, "_err"}, 32'(timeout_err), 32'(e.err));
        chk({e.tag, "_sum"}, 32'(lat_sum), 32'(e.sum));
        chk({e.tag, "_min"}, 32'(lat_min), 32'(e.mn));
        chk({e.tag, "_max"}, 32'(lat_max), 32'(e.mx));
        $display("txn %s err=%0b sum=%0d min=%0d max=%0d (exp err=%0b sum=%0d min=%0d max=%0d)",
                 e.tag, timeout_err, lat_sum, lat_min, lat_max, e.err, e.sum, e.mn, e.mx);
    endtask

    task automatic set_chain(input int dr, input int df);
        tap_r = 8'(dr - 1);
        tap_f = 8'(df - 1);
        repeat (300) @(negedge clk);
    endtask

    task automatic do_start(input int nr, input int tmo);
        @(negedge clk);
        start = 1'b1;
        num_runs = RUN_W'(nr);
        timeout = CNT_W'(tmo);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_launches(input string tag, input int l0, input int n);
        for (int i = 0; i < 5000 && (n_launch - l0) < n; i++) @(negedge clk);
        chk({tag, "_launch_wait"}, 32'(n_launch - l0), 32'(n));
    endtask

    // Full sequence; optionally pulses start in the done cycle, which must be ignored
    task automatic run_txn(input string tag, input int nr, input int tmo,
                           input int dr, input int df, input bit coincident);
        int l0, d0, t0, cyc;
        set_chain(dr, df);
        sb_q.push_back(model(tag, nr, tmo, dr, df));
        l0 = n_launch; d0 = n_done; t0 = n_test_cyc;
        do_start(nr, tmo);
        chk({tag, "_busy_on"}, 32'(busy), 32'd1);
        cyc = 0;
        while (!done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
        if (nr == 0) chk({tag, "_done_lat"}, 32'(cyc), 32'd0);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd1);
        chk({tag, "_test_at_done"}, 32'(chain_test), 32'd0);
        if (coincident) begin
            start = 1'b1;
            num_runs = RUN_W'(1);
        end
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_off"}, 32'(busy), 32'd0);
        chk({tag, "_done_off"}, 32'(done), 32'd0);
        compare_results();
        repeat (5) @(negedge clk);
        if (coincident) chk({tag, "_start_ignored"}, 32'(busy), 32'd0);
        chk({tag, "_done_cnt"}, 32'(n_done - d0), 32'd1);
        chk({tag, "_launch_cnt"}, 32'(n_launch - l0), 32'(model(tag, nr, tmo, dr, df).launches));
        if (nr == 0) chk({tag, "_test_cyc"}, 32'(n_test_cyc - t0), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_din"}, 32'(chain_din), 32'd0);
        chk({tag, "_test"}, 32'(chain_test), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    typedef struct {
        string tag;
        int    nr;
        int    tmo;
        int    dr;
        int    df;
        bit    coin;
    } cfg_t;

    cfg_t cfgs[$];

    initial begin
        int   l0, d0;
        exp_t e;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        sb_q.push_back(model("rst0", 0, 0, 1, 1));
        compare_results();
        rst = 1'b0;

        cfgs.push_back('{"sym5",     4, 100,   5,   5, 1'b1});
        cfgs.push_back('{"tmo_long", 3,  50, 200, 200, 1'b0});
        cfgs.push_back('{"zero_runs",0, 100,   5,   5, 1'b0});
        cfgs.push_back('{"asym",     2, 100,   3,   7, 1'b0});
        cfgs.push_back('{"tmo_zero", 2,   0,   5,   5, 1'b0});
        cfgs.push_back('{"tmo_eq",   2,   7,   5,   5, 1'b0});
        cfgs.push_back('{"tmo_lt",   2,   6,   5,   5, 1'b0});
        cfgs.push_back('{"sym4x3",   3, 1000,  4,   4, 1'b0});
        foreach (cfgs[i])
            run_txn(cfgs[i].tag, cfgs[i].nr, cfgs[i].tmo, cfgs[i].dr, cfgs[i].df, cfgs[i].coin);

        // Abort in the WAIT of run 2: first run recorded, no done pulse
        set_chain(5, 5);
        e = model("abort", 1, 100, 5, 5);
        e.launches = 2;
        sb_q.push_back(e);
        l0 = n_launch; d0 = n_done;
        do_start(3, 100);
        wait_launches("abort", l0, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_reset_outputs("abort");
        repeat (20) @(negedge clk);
        chk("abort_no_done", 32'(n_done - d0), 32'd0);
        chk("abort_launches", 32'(n_launch - l0), 32'(e.launches));
        compare_results();

        // Reset mid-WAIT: outputs return to reset values while rst is still high
        set_chain(5, 5);
        sb_q.push_back(model("rst_mid", 0, 0, 5, 5));
        l0 = n_launch;
        do_start(2, 100);
        wait_launches("rst_mid", l0, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        compare_results();
        @(negedge clk);
        rst = 1'b0;
        run_txn("after_rst", 2, 100, 5, 5, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
